// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
//   Line-granular backing store on the far side of the data cache's memory
//   port. Line-fill reads are queued in a small FIFO and answered in order,
//   one line every MEM_LATENCY cycles. Dirty-line write-backs are absorbed
//   into the storage array immediately, with no backpressure.
//
// Ports
//   clk             clock, all state on the rising edge
//   rst             asynchronous, active-low reset
//   mem_req         read request (level, held until its response)
//   mem_req_addr    read byte address
//   mem_write       write-back strobe, one line per asserted cycle
//   mem_write_addr  write byte address
//   mem_write_data  write line
//   mem_res         response valid, one-cycle pulse
//   mem_res_addr    line address of the response (offset bits zero)
//   mem_res_data    response line data
//   pending         queued + in-service read count
// ---------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif

module main_memory #(
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int LINE_SIZE   = `CACHE_LINE_SIZE,
  parameter int MEM_LINES   = 1024,
  parameter int MEM_LATENCY = 5,
  parameter int REQ_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_req,
  input  logic [WORD_SIZE-1:0]         mem_req_addr,
  input  logic                         mem_write,
  input  logic [WORD_SIZE-1:0]         mem_write_addr,
  input  logic [LINE_SIZE-1:0]         mem_write_data,
  output logic                         mem_res,
  output logic [WORD_SIZE-1:0]         mem_res_addr,
  output logic [LINE_SIZE-1:0]         mem_res_data,
  output logic [$clog2(REQ_DEPTH):0]   pending
);

  localparam int OFF = $clog2(LINE_SIZE / 8);
  localparam int IDX = $clog2(MEM_LINES);
  localparam int PTR = $clog2(REQ_DEPTH);
  localparam int PW  = PTR + 1;
  localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [PW-1:0] FULL_CNT   = PW'(REQ_DEPTH);
  localparam logic [CW-1:0] LAT_RELOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Storage array (deliberately not reset)
  logic [LINE_SIZE-1:0] store_r [MEM_LINES];

  // Request FIFO of line addresses
  logic [WORD_SIZE-1:0] q_addr_r [REQ_DEPTH];
  logic [REQ_DEPTH-1:0] q_valid_r;
  logic [PTR-1:0]       rd_ptr_r;
  logic [PTR-1:0]       wr_ptr_r;
  logic [PW-1:0]        count_r;

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;

  logic                 mem_res_r;
  logic [WORD_SIZE-1:0] mem_res_addr_r;
  logic [LINE_SIZE-1:0] mem_res_data_r;

  logic [WORD_SIZE-1:0] req_line_s;
  logic [WORD_SIZE-1:0] head_line_s;
  logic [IDX-1:0]       head_idx_s;
  logic [IDX-1:0]       wr_idx_s;
  logic [LINE_SIZE-1:0] rd_line_s;
  logic                 dup_s;
  logic                 full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 unused_s;

  assign req_line_s  = {mem_req_addr[WORD_SIZE-1:OFF], {OFF{1'b0}}};
  assign head_line_s = q_addr_r[rd_ptr_r];
  assign head_idx_s  = head_line_s[OFF +: IDX];
  assign wr_idx_s    = mem_write_addr[OFF +: IDX];

  // Upper write-address bits alias and offset bits are ignored by design
  assign unused_s = ^{mem_write_addr[WORD_SIZE-1:OFF+IDX], mem_write_addr[OFF-1:0],
                      mem_req_addr[OFF-1:0]};

  // Write-first: a write-back landing on the completing line is forwarded
  assign rd_line_s = (mem_write && (wr_idx_s == head_idx_s)) ? mem_write_data
                                                              : store_r[head_idx_s];

  // The popping entry still counts as in service, so a held mem_req is not re-queued
  assign pop_s  = (state_r == BUSY) && (cnt_r == {CW{1'b0}});
  assign full_s = (count_r == FULL_CNT) && !pop_s;
  assign push_s = mem_req && !dup_s && !full_s;

  // Dedupe search over every occupied FIFO slot
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < REQ_DEPTH; i++) begin
      if (q_valid_r[i] && (q_addr_r[i] == req_line_s)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
  end

  // Service FSM next-state and latency counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (push_s) begin
          state_s = BUSY;
          cnt_s   = LAT_RELOAD;
        end else begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      end
      BUSY: begin
        if (pop_s) begin
          if ((count_r > PW'(1)) || push_s) begin
            state_s = BUSY;
            cnt_s   = LAT_RELOAD;
          end else begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          state_s = BUSY;
          cnt_s   = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request FIFO: pop frees the head slot before a same-edge push may reuse it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r  <= {PTR{1'b0}};
      wr_ptr_r  <= {PTR{1'b0}};
      count_r   <= {PW{1'b0}};
      q_valid_r <= {REQ_DEPTH{1'b0}};
      for (int i = 0; i < REQ_DEPTH; i++) begin
        q_addr_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else begin
      if (pop_s) begin
        q_valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r            <= rd_ptr_r + PTR'(1);
      end
      if (push_s) begin
        q_valid_r[wr_ptr_r] <= 1'b1;
        q_addr_r[wr_ptr_r]  <= req_line_s;
        wr_ptr_r            <= wr_ptr_r + PTR'(1);
      end
      count_r <= count_r + PW'(push_s) - PW'(pop_s);
    end
  end

  // Response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_res_r      <= 1'b0;
      mem_res_addr_r <= {WORD_SIZE{1'b0}};
      mem_res_data_r <= {LINE_SIZE{1'b0}};
    end else begin
      mem_res_r <= pop_s;
      if (pop_s) begin
        mem_res_addr_r <= head_line_s;
        mem_res_data_r <= rd_line_s;
      end
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (mem_write) begin
      store_r[wr_idx_s] <= mem_write_data;
    end
  end

  assign mem_res      = mem_res_r;
  assign mem_res_addr = mem_res_addr_r;
  assign mem_res_data = mem_res_data_r;
  assign pending      = count_r;

endmodule

// File: tb/tb_main_memory.sv
// ---------------------------------------------------------------------------
// tb_main_memory
//   Directed, self-checking bench for main_memory with default parameters
//   (32-bit addresses, 128-bit lines, latency 5, request depth 4).
// ---------------------------------------------------------------------------
module tb_main_memory;

  logic         clk;
  logic         rst;
  logic         mem_req;
  logic [31:0]  mem_req_addr;
  logic         mem_write;
  logic [31:0]  mem_write_addr;
  logic [127:0] mem_write_data;
  logic         mem_res;
  logic [31:0]  mem_res_addr;
  logic [127:0] mem_res_data;
  logic [2:0]   pending;

  int n_checks;
  int n_fail;

  main_memory dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_req_addr   (mem_req_addr),
    .mem_write      (mem_write),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_res        (mem_res),
    .mem_res_addr   (mem_res_addr),
    .mem_res_data   (mem_res_data),
    .pending        (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (mem_res !== 1'b0 || pending !== 3'd0 || mem_res_addr !== 32'h0 || mem_res_data !== 128'h0) begin
      $display("FAIL reset_outputs: res=%b pend=%0d addr=%h (need all zero)", mem_res, pending, mem_res_addr);
      n_fail++;
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (mem_res !== 1'b0 || pending !== 3'd0) begin
        $display("FAIL idle_quiet: cycle %0d res=%b pend=%0d (need 0/0)", i, mem_res, pending);
        n_fail++;
      end
    end
  endtask

  task automatic test_single_read();
    int n;
    int max_pend;
    dut.store_r[16] = 128'hDEADBEEF_00000001_00000002_00000003;
    mem_req      = 1'b1;
    mem_req_addr = 32'h0000_010C;
    tick();
    n = 0;
    max_pend = int'(pending);
    while (mem_res !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    n_checks++;
    if (n !== 5) begin
      $display("FAIL single_latency: got %0d edges, need 5", n);
      n_fail++;
    end
    n_checks++;
    if (mem_res_addr !== 32'h0000_0100) begin
      $display("FAIL single_addr: got %h need 00000100", mem_res_addr);
      n_fail++;
    end
    n_checks++;
    if (mem_res_data !== 128'hDEADBEEF_00000001_00000002_00000003) begin
      $display("FAIL single_data: got %h need deadbeef000000010000000200000003", mem_res_data);
      n_fail++;
    end
    n_checks++;
    if (max_pend !== 1) begin
      $display("FAIL single_dedupe_pending: peak %0d need 1", max_pend);
      n_fail++;
    end
    mem_req = 1'b0;
    tick();
    n_checks++;
    if (mem_res !== 1'b0 || pending !== 3'd0) begin
      $display("FAIL single_pulse: res=%b pend=%0d need 0/0", mem_res, pending);
      n_fail++;
    end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_res === 1'b1) n++;
    end
    n_checks++;
    if (n !== 0) begin
      $display("FAIL single_no_duplicate: %0d extra responses need 0", n);
      n_fail++;
    end
  endtask

  task automatic test_write_read();
    int n;
    mem_write      = 1'b1;
    mem_write_addr = 32'h0000_0200;
    mem_write_data = {16{8'hA5}};
    tick();
    mem_write      = 1'b0;
    mem_req        = 1'b1;
    mem_req_addr   = 32'h0000_0204;
    tick();
    n = 0;
    while (mem_res !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    mem_req = 1'b0;
    n_checks++;
    if (n !== 5 || mem_res_addr !== 32'h0000_0200) begin
      $display("FAIL wr_rd_timing: edges=%0d addr=%h need 5/00000200", n, mem_res_addr);
      n_fail++;
    end
    n_checks++;
    if (mem_res_data !== {16{8'hA5}}) begin
      $display("FAIL wr_rd_data: got %h need a5 repeated", mem_res_data);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_forward();
    dut.store_r[48] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    mem_req      = 1'b1;
    mem_req_addr = 32'h0000_0300;
    tick();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (mem_res !== 1'b0) begin
      $display("FAIL fwd_early: res=%b need 0 before edge 5", mem_res);
      n_fail++;
    end
    mem_write      = 1'b1;
    mem_write_addr = 32'h0000_0300;
    mem_write_data = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
    tick();
    mem_write = 1'b0;
    mem_req   = 1'b0;
    n_checks++;
    if (mem_res !== 1'b1 || mem_res_data !== 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0) begin
      $display("FAIL fwd_data: res=%b data=%h need 1/cafef00d0badc0de123456789abcdef0", mem_res, mem_res_data);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_queue_order();
    int n;
    logic [127:0] exp_line [5];
    for (int i = 0; i < 5; i++) begin
      exp_line[i] = {32'hC0DE_0000 + 32'(i), 32'h0, 32'h0, 32'h0000_1000 * 32'(i + 1)};
      dut.store_r[i] = exp_line[i];
    end
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_req_addr = 32'h10 * 32'(i);
      tick();
    end
    n_checks++;
    if (pending !== 3'd4 || mem_res !== 1'b0) begin
      $display("FAIL queue_full: pend=%0d res=%b need 4/0", pending, mem_res);
      n_fail++;
    end
    tick();
    n_checks++;
    if (mem_res !== 1'b1 || mem_res_addr !== 32'h0 || mem_res_data !== exp_line[0]) begin
      $display("FAIL queue_first: res=%b addr=%h data=%h need 1/00000000/%h", mem_res, mem_res_addr, mem_res_data, exp_line[0]);
      n_fail++;
    end
    n_checks++;
    if (pending !== 3'd4) begin
      $display("FAIL queue_push_on_pop: pend=%0d need 4", pending);
      n_fail++;
    end
    for (int r = 1; r < 5; r++) begin
      tick();
      n = 1;
      while (mem_res !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      n_checks++;
      if (n !== 5 || mem_res_addr !== 32'h10 * 32'(r) || mem_res_data !== exp_line[r]) begin
        $display("FAIL queue_order_%0d: edges=%0d addr=%h data=%h need 5/%h/%h", r, n, mem_res_addr, mem_res_data, 32'h10 * 32'(r), exp_line[r]);
        n_fail++;
      end
    end
    mem_req = 1'b0;
    tick();
    n_checks++;
    if (pending !== 3'd0 || mem_res !== 1'b0) begin
      $display("FAIL queue_drain: pend=%0d res=%b need 0/0", pending, mem_res);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mem_write      = 1'b1;
    mem_write_addr = 32'h0000_0500;
    mem_write_data = 128'h5A5A5A5A_00C0FFEE_76543210_FEDCBA98;
    tick();
    mem_write    = 1'b0;
    mem_req      = 1'b1;
    mem_req_addr = 32'h0000_0500;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_res !== 1'b0 || pending !== 3'd0 || mem_res_addr !== 32'h0 || mem_res_data !== 128'h0) begin
      $display("FAIL async_reset: res=%b pend=%0d addr=%h data=%h need all zero", mem_res, pending, mem_res_addr, mem_res_data);
      n_fail++;
    end
    mem_req = 1'b0;
    #2;
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_res === 1'b1 || pending !== 3'd0) n++;
    end
    n_checks++;
    if (n !== 0) begin
      $display("FAIL reset_lost_request: %0d active cycles need 0", n);
      n_fail++;
    end
    mem_req      = 1'b1;
    mem_req_addr = 32'h0000_0508;
    tick();
    n = 0;
    while (mem_res !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    mem_req = 1'b0;
    n_checks++;
    if (n !== 5 || mem_res_data !== 128'h5A5A5A5A_00C0FFEE_76543210_FEDCBA98) begin
      $display("FAIL reset_storage_kept: edges=%0d data=%h need 5/5a5a5a5a00c0ffee76543210fedcba98", n, mem_res_data);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    mem_req        = 1'b0;
    mem_req_addr   = 32'h0;
    mem_write      = 1'b0;
    mem_write_addr = 32'h0;
    mem_write_data = 128'h0;
    test_reset();
    test_single_read();
    test_write_read();
    test_forward();
    test_queue_order();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
